dap_swj_seq: RTL

DAP_SWJ_SEQ -- requirements
Module: dap_swj_seq

---
 rtl/dap_swj_seq_pkg.sv | 29 ++
 rtl/dap_swj_clkgen.sv | 27 ++
 rtl/dap_swj_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dap_swj_seq_pkg.sv
// Shared DAP command constants, SWJ sequencer state encoding and helpers.
package dap_swj_seq_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_CNT_W  = 9;
  localparam int unsigned BIT_IDX_W  = 3;
  localparam int unsigned RAM_ADDR_W = 10;

  localparam logic [BYTE_W-1:0]     DAP_CMD_SWJ_SEQUENCE = 8'h12;
  localparam logic [BYTE_W-1:0]     DAP_OK               = 8'h00;
  localparam logic [RAM_ADDR_W-1:0] SWJ_RESP_LEN         = 10'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_CNT  = 3'd1,
    S_GET_DATA = 3'd2,
    S_CLK_LOW  = 3'd3,
    S_CLK_HIGH = 3'd4,
    S_RESP0    = 3'd5,
    S_RESP1    = 3'd6,
    S_DONE     = 3'd7
  } swj_state_t;

  // A request count byte of zero encodes a 256-bit sequence.
  function automatic logic [BIT_CNT_W-1:0] swj_bit_count(input logic [BYTE_W-1:0] b);
    return (b == '0) ? BIT_CNT_W'(256) : BIT_CNT_W'(b);
  endfunction

endpackage

// File: rtl/dap_swj_clkgen.sv
// SWCLK half-period timer: load with the half-period value, tick on the last cycle of the phase.
module dap_swj_clkgen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_half,
  output logic                 o_tick_c
);

  logic [DIV_WIDTH-1:0] r_cnt;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_half;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

  assign o_tick_c = (r_cnt == '0);

endmodule

// File: rtl/dap_swj_seq.sv
// DAP_SWJ_Sequence worker: reads count and data bytes, clocks bits out on SWCLK/SWDIO, writes the response.
module dap_swj_seq
  import dap_swj_seq_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  start,
  output logic                  done,
  input  logic                  dap_in_tvalid,
  output logic                  dap_in_tready,
  input  logic [BYTE_W-1:0]     dap_in_tdata,
  output logic [RAM_ADDR_W-1:0] ram_write_addr,
  output logic [BYTE_W-1:0]     ram_write_data,
  output logic                  ram_write_en,
  output logic [RAM_ADDR_W-1:0] packet_len,
  output logic                  SWCLK_TCK_O,
  output logic                  SWDIO_TMS_O,
  output logic                  SWDIO_TMS_T
);

  swj_state_t            r_state, w_state_next;
  logic [DIV_WIDTH-1:0]  r_clk_div;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic [BIT_IDX_W-1:0]  r_bit_idx, w_bit_idx_next;
  logic [BYTE_W-1:0]     r_shift, w_shift_next;

  logic                  r_done, w_done_next;
  logic                  r_tready, w_tready_next;
  logic                  r_ram_en, w_ram_en_next;
  logic [RAM_ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [BYTE_W-1:0]     r_ram_data, w_ram_data_next;
  logic [RAM_ADDR_W-1:0] r_packet_len, w_packet_len_next;
  logic                  r_swclk, w_swclk_next;
  logic                  r_swdio_o, w_swdio_o_next;
  logic                  r_swdio_t, w_swdio_t_next;

  logic                  w_start_ok;
  logic                  w_xfer;
  logic                  w_tick;
  logic                  w_load;

  assign w_start_ok = (r_state == S_IDLE) && start && enable;
  assign w_xfer     = dap_in_tvalid && r_tready;

  dap_swj_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_load),
    .i_half   (r_clk_div),
    .o_tick_c (w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, datapath updates and next values of every registered output.
  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt;
    w_bit_idx_next    = r_bit_idx;
    w_shift_next      = r_shift;
    w_done_next       = 1'b0;
    w_tready_next     = 1'b0;
    w_ram_en_next     = 1'b0;
    w_ram_addr_next   = r_ram_addr;
    w_ram_data_next   = r_ram_data;
    w_packet_len_next = r_packet_len;
    w_swclk_next      = r_swclk;
    w_swdio_o_next    = r_swdio_o;
    w_swdio_t_next    = r_swdio_t;
    w_load            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next   = S_GET_CNT;
          w_bit_cnt_next = '0;
          w_bit_idx_next = '0;
          w_shift_next   = '0;
        end
      end
      S_GET_CNT: begin
        if (w_xfer) begin
          w_bit_cnt_next = swj_bit_count(dap_in_tdata);
          w_state_next   = S_GET_DATA;
        end
      end
      S_GET_DATA: begin
        if (w_xfer) begin
          w_shift_next   = dap_in_tdata;
          w_bit_idx_next = '0;
          w_state_next   = S_CLK_LOW;
        end
      end
      S_CLK_LOW: begin
        if (w_tick) begin
          w_state_next = S_CLK_HIGH;
        end
      end
      S_CLK_HIGH: begin
        if (w_tick) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
          w_bit_cnt_next = r_bit_cnt - BIT_CNT_W'(1);
          if (r_bit_cnt == BIT_CNT_W'(1)) begin
            w_state_next = S_RESP0;
          end else if (r_bit_idx == BIT_IDX_W'(7)) begin
            w_state_next = S_GET_DATA;
          end else begin
            w_state_next = S_CLK_LOW;
          end
        end
      end
      S_RESP0: w_state_next = S_RESP1;
      S_RESP1: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Losing enable abandons the sequence from any busy state.
    if (!enable && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    w_tready_next = (w_state_next == S_GET_CNT) || (w_state_next == S_GET_DATA);
    w_done_next   = (w_state_next == S_DONE);
    w_load        = ((w_state_next == S_CLK_LOW) || (w_state_next == S_CLK_HIGH)) &&
                    (w_state_next != r_state);

    case (w_state_next)
      S_RESP0: begin
        w_ram_en_next   = 1'b1;
        w_ram_addr_next = RAM_ADDR_W'(0);
        w_ram_data_next = DAP_CMD_SWJ_SEQUENCE;
      end
      S_RESP1: begin
        w_ram_en_next   = 1'b1;
        w_ram_addr_next = RAM_ADDR_W'(1);
        w_ram_data_next = DAP_OK;
      end
      default: ;
    endcase

    if (w_start_ok) begin
      w_packet_len_next = '0;
    end else if (w_state_next == S_DONE) begin
      w_packet_len_next = SWJ_RESP_LEN;
    end

    case (w_state_next)
      S_IDLE: begin
        w_swclk_next   = 1'b1;
        w_swdio_o_next = 1'b1;
        w_swdio_t_next = 1'b1;
      end
      S_CLK_LOW: begin
        w_swclk_next   = 1'b0;
        w_swdio_o_next = w_shift_next[0];
        w_swdio_t_next = 1'b0;
      end
      S_CLK_HIGH: begin
        w_swclk_next   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_div    <= '0;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_done       <= 1'b0;
      r_tready     <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_packet_len <= '0;
      r_swclk      <= 1'b1;
      r_swdio_o    <= 1'b1;
      r_swdio_t    <= 1'b1;
    end else begin
      if (w_start_ok) begin
        r_clk_div <= clk_div;
      end
      r_bit_cnt    <= w_bit_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
      r_done       <= w_done_next;
      r_tready     <= w_tready_next;
      r_ram_en     <= w_ram_en_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_data   <= w_ram_data_next;
      r_packet_len <= w_packet_len_next;
      r_swclk      <= w_swclk_next;
      r_swdio_o    <= w_swdio_o_next;
      r_swdio_t    <= w_swdio_t_next;
    end
  end

  assign done           = r_done;
  assign dap_in_tready  = r_tready;
  assign ram_write_en   = r_ram_en;
  assign ram_write_addr = r_ram_addr;
  assign ram_write_data = r_ram_data;
  assign packet_len     = r_packet_len;
  assign SWCLK_TCK_O    = r_swclk;
  assign SWDIO_TMS_O    = r_swdio_o;
  assign SWDIO_TMS_T    = r_swdio_t;

endmodule
